// File: rtl/miriscv_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// read-latency ceiling and the set of legal byte-enable patterns.
package miriscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam int unsigned RD_LATENCY_MAX = 4;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  // Naturally aligned byte, halfword or word lane patterns only.
  function automatic logic be_is_legal(input logic [3:0] be);
    case (be)
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
      BE_HALF0, BE_HALF1, BE_WORD: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_be_ram.sv
// Word-organised RAM with four byte lanes.
//   clk_i            : clock
//   we_i / be_i      : write strobe and per-lane enables
//   waddr_i/wdata_i  : write word index and data
//   raddr_i/rdata_o  : read word index and combinational read data
// Contents are never reset.
module miriscv_be_ram #(
  parameter int unsigned WORDS = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(WORDS)-1:0] waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic [$clog2(WORDS)-1:0] raddr_i,
  output logic [31:0]              rdata_o
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_comb rdata_o = mem[raddr_i];

endmodule

// File: rtl/miriscv_data_ram.sv
// Default data RAM on the core's LSU bus (target side).
//   clk_i, arstn_i        : clock, asynchronous active-low reset
//   data_req_i/we/be/addr/wdata : request from the LSU
//   data_rdata_o          : read data, held until the next read response
//   data_rvalid_o         : one-cycle response pulse, RD_LATENCY after acceptance
//   data_busy_o           : high while waiting out read latency
//   data_err_o            : access error, only when DATA_RAM_ERR_EN is defined
// Optional build macro: DATA_RAM_ERR_EN (range / byte-enable checking).
module miriscv_data_ram
  import miriscv_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_rvalid_o,
  output logic        data_busy_o
`ifdef DATA_RAM_ERR_EN
  ,
  output logic        data_err_o
`endif
);

  localparam int unsigned IDX_W = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W = $clog2(RD_LATENCY_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  mem_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept;
  logic [IDX_W-1:0] idx, cap_idx, rd_idx;
  logic             cap_we, cap_err, acc_err, rd_err;
  logic             wr_en, rd_sample;
  logic [31:0]      ram_rdata;

  always_comb idx = IDX_W'((data_addr_i - BASE_ADDR) >> 2);

`ifdef DATA_RAM_ERR_EN
  localparam logic [32:0] SPAN = 33'(RAM_WORDS) << 2;
  logic [31:0] offset;

  always_comb begin
    offset  = data_addr_i - BASE_ADDR;
    acc_err = ({1'b0, offset} >= SPAN) || !be_is_legal(data_be_i);
  end

  always_comb data_err_o = (state == RESP) && cap_err;
`else
  always_comb acc_err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        if (data_req_i) begin
          accept = 1'b1;
          if (RD_LATENCY > 1) begin
            state_next = WAIT;
            cnt_next   = CNT_W'(1);
          end else begin
            state_next = RESP;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt == CNT_LAST) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb wr_en = accept && data_we_i && !acc_err;

  // Single-cycle latency samples the live request at acceptance; longer
  // latencies sample the captured request on the last WAIT edge.
  always_comb begin
    if (RD_LATENCY == 1) begin
      rd_sample = accept && !data_we_i;
      rd_idx    = idx;
      rd_err    = acc_err;
    end else begin
      rd_sample = (state == WAIT) && (cnt == CNT_LAST) && !cap_we;
      rd_idx    = cap_idx;
      rd_err    = cap_err;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state        <= IDLE;
      cnt          <= '0;
      cap_we       <= 1'b0;
      cap_idx      <= '0;
      cap_err      <= 1'b0;
      data_rdata_o <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        cap_we  <= data_we_i;
        cap_idx <= idx;
        cap_err <= acc_err;
      end
      if (rd_sample) begin
        data_rdata_o <= rd_err ? '0 : ram_rdata;
      end
    end
  end

  always_comb data_rvalid_o = (state == RESP);
  always_comb data_busy_o   = (state == WAIT);

  miriscv_be_ram #(
    .WORDS (RAM_WORDS)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .be_i    (data_be_i),
    .waddr_i (idx),
    .wdata_i (data_wdata_i),
    .raddr_i (rd_idx),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_miriscv_data_ram.sv
module tb_miriscv_data_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int          G   = g;
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int unsigned RW  = (g == 1) ? 64 : (g == 2) ? 256 : 1024;
    localparam logic [31:0] BA  = (g == 1) ? 32'h0000_1000 : 32'h0000_0000;

    logic        rst, req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        rvalid, busy;
`ifdef DATA_RAM_ERR_EN
    logic        err;
`endif
    bit          fin = 1'b0;

    miriscv_data_ram #(
      .RAM_WORDS  (RW),
      .BASE_ADDR  (BA),
      .RD_LATENCY (LAT)
    ) u_dut (
`ifdef DATA_RAM_ERR_EN
      .data_err_o    (err),
`endif
      .clk_i         (clk),
      .arstn_i       (rst),
      .data_req_i    (req),
      .data_we_i     (we),
      .data_be_i     (be),
      .data_addr_i   (addr),
      .data_wdata_i  (wdata),
      .data_rdata_o  (rdata),
      .data_rvalid_o (rvalid),
      .data_busy_o   (busy)
    );

    // Reference model: an array of words plus the edge numbers at which the
    // current request was accepted and must be answered.
    logic [31:0] mem [int unsigned];
    int          e = 0, next_ok = 0, acc_at = -1, resp_at = -1;
    logic        exp_rvalid = 1'b0, exp_busy = 1'b0, exp_err = 1'b0, rd_known = 1'b1;
    logic [31:0] exp_rdata = '0;
    logic        p_we = 1'b0, p_err = 1'b0, bad;
    logic [31:0] p_val = '0, merged;
    int unsigned w;

    initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        next_ok = 0; acc_at = -1; resp_at = -1;
        exp_rvalid = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
        exp_rdata = '0; rd_known = 1'b1;
      end else begin
        e++;
        if (req && e >= next_ok) begin
          w   = ((addr - BA) >> 2) % RW;
          bad = 1'b0;
`ifdef DATA_RAM_ERR_EN
          bad = (64'(addr - BA) >= 64'(RW) * 4) ||
                !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
`endif
          acc_at  = e;
          resp_at = e + LAT - 1;
          next_ok = e + LAT;
          p_we    = we;
          p_err   = bad;
          if (we && !bad) begin
            merged = mem.exists(w) ? mem[w] : 'x;
            for (int i = 0; i < 4; i++) if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
            mem[w] = merged;
          end
          p_val = mem.exists(w) ? mem[w] : 'x;
        end
        exp_rvalid = (e == resp_at);
        exp_busy   = (e >= acc_at) && (e < resp_at);
        exp_err    = exp_rvalid && p_err;
        if (exp_rvalid && !p_we) begin
          exp_rdata = p_err ? '0 : p_val;
          rd_known  = !$isunknown(exp_rdata);
        end
      end
    end

    function automatic void c(input string s, input logic [31:0] a, input logic [31:0] x);
      chk($sformatf("g%0d %s", G, s), a, x);
    endfunction

    initial forever begin
      @(negedge clk);
      c("model rvalid", 32'(rvalid), 32'(exp_rvalid));
      c("model busy", 32'(busy), 32'(exp_busy));
      if (rd_known) c("model rdata", rdata, exp_rdata);
`ifdef DATA_RAM_ERR_EN
      c("model err", 32'(err), 32'(exp_err));
`endif
    end

    task automatic do_reset();
      rst = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
      @(negedge clk);
      c("reset rvalid", 32'(rvalid), 32'd0);
      c("reset busy", 32'(busy), 32'd0);
      c("reset rdata", rdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    // with req still asserted.
    task automatic issue(input logic w_i, input logic [3:0] b_i, input logic [31:0] a_i,
                         input logic [31:0] d_i);
      int n = 0;
      req = 1'b1; we = w_i; be = b_i; addr = a_i; wdata = d_i;
      while (busy && n < 16) begin
        @(negedge clk);
        n++;
      end
      c("accept busy released", 32'(busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a_i, input logic [31:0] expv);
      int n = 0;
      issue(1'b0, 4'hF, a_i, '0);
      req = 1'b0;
      while (!rvalid && n < 8) begin
        @(negedge clk);
        n++;
      end
      c({nm, " rvalid"}, 32'(rvalid), 32'd1);
      c({nm, " rdata"}, rdata, expv);
    endtask

    task automatic run_random();
      int unsigned words [8] = '{0, 1, 2, 3, 5, 9, RW - 2, RW - 1};
      foreach (words[i]) issue(1'b1, 4'hF, BA + 32'(4 * words[i]), $urandom);
      for (int t = 0; t < 300; t++) begin
        int unsigned wi = words[$urandom_range(7)];
        int          ka = int'($urandom_range(4));
        int          k;
        logic [31:0] a;
        k = (ka == 0) ? -1 : (ka <= 2) ? 0 : ka - 2;
        a = BA + 32'(4 * wi) + 32'(k * 4 * int'(RW)) + 32'($urandom_range(3));
        issue($urandom_range(1) == 1, 4'($urandom), a, $urandom);
        if ($urandom_range(2) != 0) begin
          req = 1'b0;
          repeat ($urandom_range(2)) @(negedge clk);
        end
      end
      req = 1'b0;
      repeat (8) @(negedge clk);
    endtask

    if (g == 0) begin : g_seq
      initial begin
        do_reset();
        issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        req = 1'b0;
        rd_chk("full word read", 32'h10, 32'hDEADBEEF);
        issue(1'b1, 4'b0010, 32'h10, 32'h5555_5555);
        req = 1'b0;
        rd_chk("lane1 merge read", 32'h10, 32'hDEAD55EF);
        issue(1'b1, 4'hF, 32'h20, 32'h12345678);
        c("b2b write rvalid", 32'(rvalid), 32'd1);
        c("b2b write keeps rdata", rdata, 32'hDEAD55EF);
        issue(1'b0, 4'hF, 32'h20, '0);
        c("b2b read rvalid", 32'(rvalid), 32'd1);
        c("b2b read rdata", rdata, 32'h12345678);
        req = 1'b0;
        @(negedge clk);
        c("b2b idle rvalid", 32'(rvalid), 32'd0);
        run_random();
        fin = 1'b1;
      end
    end else if (g == 1) begin : g_seq
      initial begin
        do_reset();
        issue(1'b1, 4'hF, 32'h1008, 32'hAABBCCDD);
        issue(1'b0, 4'hF, 32'h1008, '0);
        c("lat3 c1 busy", 32'(busy), 32'd1);
        c("lat3 c1 rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        c("lat3 c2 busy", 32'(busy), 32'd1);
        c("lat3 c2 rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        c("lat3 c3 busy", 32'(busy), 32'd0);
        c("lat3 c3 rvalid", 32'(rvalid), 32'd1);
        c("lat3 c3 rdata", rdata, 32'hAABBCCDD);
        req = 1'b0;
        @(negedge clk);
        c("lat3 c4 rvalid", 32'(rvalid), 32'd0);
        run_random();
        fin = 1'b1;
      end
    end else begin : g_seq
      initial begin
        do_reset();
        issue(1'b1, 4'hF, 32'h40, 32'hCAFEF00D);
        req = 1'b0;
        rd_chk("pre-reset read", 32'h40, 32'hCAFEF00D);
        issue(1'b0, 4'hF, 32'h40, '0);
        @(posedge clk);
        #2;
        c("second wait busy", 32'(busy), 32'd1);
        rst = 1'b0;
        req = 1'b0;
        #1;
        c("mid-wait reset rvalid", 32'(rvalid), 32'd0);
        c("mid-wait reset busy", 32'(busy), 32'd0);
        c("mid-wait reset rdata", rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          c("no rvalid after reset", 32'(rvalid), 32'd0);
        end
        rd_chk("post-reset read", 32'h40, 32'hCAFEF00D);
        run_random();
        fin = 1'b1;
      end
    end
  end

  initial begin
    int  n = 0;
    logic all_fin;
    all_fin = 1'b0;
    while (!all_fin && n < 50000) begin
      @(posedge clk);
      n++;
      all_fin = g_inst[0].fin && g_inst[1].fin && g_inst[2].fin;
    end
    chk("all sequences finished", 32'(all_fin), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
